line_window_3x3_rgb888: RTL

Builds a 3x3 RGB888 pixel window from a raster-order pixel stream using two internal line buffers. It sits directly upstream of the 3x3 RGB convolution stage. Its nine window outputs and valid strobe connect straight to that stage's window inputs and enable. Only fully interior windows are emitted, with no padding, so one frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/lwin_line_ram.sv | 41 ++++
 rtl/line_window_3x3_rgb888.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared definitions for the RGB888 3x3 window / convolution pipeline.
//   - RGB_W / CH_W      : pixel and per-channel widths
//   - *_LSB             : channel slice positions inside an RGB888 word
//   - WIN_TAPS          : number of pixels in a 3x3 window
//   - cnt_width()       : width of a counter / address that spans 0..n-1
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int RGB_W    = 24;
    localparam int CH_W     = 8;

    localparam int R_LSB    = 16;
    localparam int G_LSB    = 8;
    localparam int B_LSB    = 0;

    localparam int WIN_TAPS = 9;

    // Width needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lwin_line_ram.sv
// ---------------------------------------------------------------------------
// lwin_line_ram
//   Simple dual-port line RAM, DEPTH x DATA_W, one write port and one
//   registered read port on the same clock. A read of the address being
//   written in the same cycle returns the old contents (read-before-write).
//   No reset on the storage or the read register so it maps onto block RAM
//   (or distributed RAM for short lines).
//
// Ports
//   clk_i      : clock, rising edge
//   we_i       : write enable
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address
//   rd_data_o  : read data, valid one cycle after rd_addr_i is presented
// ---------------------------------------------------------------------------
module lwin_line_ram
    import conv_pkg::*;
#(
    parameter int DEPTH  = 640,
    parameter int DATA_W = RGB_W,
    parameter int ADDR_W = cnt_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/line_window_3x3_rgb888.sv
// ---------------------------------------------------------------------------
// line_window_3x3_rgb888
//   Turns a raster-order RGB888 pixel stream into 3x3 windows for the
//   downstream 3x3 convolution stage. Only fully interior windows are
//   emitted: one window per accepted pixel at (row>=2, col>=2).
//
//   Optional build macro: LWIN_SOF_RESYNC_EN
//     When defined, adds i_sof. An accepted pixel with i_sof=1 is taken as
//     (0,0) regardless of the counters; a truncated frame never pulses
//     o_frame_done.
//
// Ports
//   iClk          : clock, rising edge
//   iRst_n        : asynchronous active-low reset
//   i_valid       : pixel accepted on every cycle it is high
//   i_sof         : (LWIN_SOF_RESYNC_EN only) start-of-frame marker
//   i_data        : RGB888 pixel {R,G,B}
//   o_p1..o_p9    : window, row-major; o_p1=(r-2,c-2), o_p5=(r-1,c-1),
//                   o_p9=(r,c). Held while o_valid=0.
//   o_valid       : window qualifier, one cycle after the accepting edge
//   o_frame_done  : pulses with the window of the last pixel of a frame
// ---------------------------------------------------------------------------
module line_window_3x3_rgb888
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = RGB_W
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             i_valid,
`ifdef LWIN_SOF_RESYNC_EN
    input  logic             i_sof,
`endif
    input  logic [PIX_W-1:0] i_data,
    output logic [PIX_W-1:0] o_p1,
    output logic [PIX_W-1:0] o_p2,
    output logic [PIX_W-1:0] o_p3,
    output logic [PIX_W-1:0] o_p4,
    output logic [PIX_W-1:0] o_p5,
    output logic [PIX_W-1:0] o_p6,
    output logic [PIX_W-1:0] o_p7,
    output logic [PIX_W-1:0] o_p8,
    output logic [PIX_W-1:0] o_p9,
    output logic             o_valid,
    output logic             o_frame_done
);

    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    // ------------------------------------------------------------------
    // Position tracking
    // ------------------------------------------------------------------
    logic             accept;
    logic             sof;
    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;
    logic             emit;
    logic             last_pix;

    assign accept = i_valid;

`ifdef LWIN_SOF_RESYNC_EN
    assign sof = i_sof;
`else
    assign sof = 1'b0;
`endif

    // Coordinates of the pixel on i_data this cycle (start-of-frame wins).
    always_comb begin
        col_cur = col_q;
        row_cur = row_q;
        if (sof) begin
            col_cur = '0;
            row_cur = '0;
        end
    end

    // Coordinates of the next pixel to be accepted.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + ROW_W'(1);
            end else begin
                col_d = col_cur + COL_W'(1);
                row_d = row_cur;
            end
        end
    end

    assign emit     = accept && (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);
    assign last_pix = accept && (row_cur == ROW_LAST) && (col_cur == COL_LAST);

    // ------------------------------------------------------------------
    // Line buffers
    //   The read port is aimed at col_d, the column of the *next* pixel,
    //   so the registered read data is already waiting when that pixel
    //   arrives. Raster order guarantees the prefetched column is never
    //   the one written in the same cycle. After a reset or resync the
    //   first pixel may see a stale prefetch; that data only lands in
    //   rows 0/1, which are overwritten before any window uses them.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] lb0_rd;   // old LB0[c] : line r-1
    logic [PIX_W-1:0] lb1_rd;   // old LB1[c] : line r-2

    lwin_line_ram #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (PIX_W),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .clk_i     (iClk),
        .we_i      (accept),
        .wr_addr_i (col_cur),
        .wr_data_i (i_data),
        .rd_addr_i (col_d),
        .rd_data_o (lb0_rd)
    );

    lwin_line_ram #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (PIX_W),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk_i     (iClk),
        .we_i      (accept),
        .wr_addr_i (col_cur),
        .wr_data_i (lb0_rd),
        .rd_addr_i (col_d),
        .rd_data_o (lb1_rd)
    );

    // ------------------------------------------------------------------
    // Window assembly
    //   sr_q keeps the two previous columns per row (2*k = older, 2*k+1 =
    //   newer); the current column comes straight from the line buffers
    //   and i_data. win_d is the window as it looks after this pixel.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] new_col [3];
    logic [PIX_W-1:0] sr_q    [6];
    logic [PIX_W-1:0] win_d   [WIN_TAPS];
    logic [PIX_W-1:0] win_q   [WIN_TAPS];
    logic             valid_q;
    logic             frame_done_q;

    assign new_col[0] = lb1_rd;   // top
    assign new_col[1] = lb0_rd;   // middle
    assign new_col[2] = i_data;   // bottom

    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        assign win_d[3*gi]     = sr_q[2*gi];
        assign win_d[3*gi + 1] = sr_q[2*gi + 1];
        assign win_d[3*gi + 2] = new_col[gi];
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                sr_q[i] <= '0;
            end
            for (int i = 0; i < WIN_TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            valid_q      <= emit;
            frame_done_q <= last_pix;
            if (accept) begin
                for (int k = 0; k < 3; k++) begin
                    sr_q[2*k]     <= sr_q[2*k + 1];
                    sr_q[2*k + 1] <= new_col[k];
                end
            end
            // Output window only moves when a window is emitted, so
            // suppressed edge columns never disturb the held value.
            if (emit) begin
                for (int i = 0; i < WIN_TAPS; i++) begin
                    win_q[i] <= win_d[i];
                end
            end
        end
    end

    assign o_p1         = win_q[0];
    assign o_p2         = win_q[1];
    assign o_p3         = win_q[2];
    assign o_p4         = win_q[3];
    assign o_p5         = win_q[4];
    assign o_p6         = win_q[5];
    assign o_p7         = win_q[6];
    assign o_p8         = win_q[7];
    assign o_p9         = win_q[8];
    assign o_valid      = valid_q;
    assign o_frame_done = frame_done_q;

endmodule
